// File: rtl/fifo_stream_drain.sv
// fifo_stream_drain
//   Read-side consumer of the CDC FIFO. It waits for the FIFO pre-fill flag,
//   then pops the show-ahead FIFO and re-emits the data as a valid/ready
//   stream framed into FRAME_LEN-beat bursts (m_last on the final beat).
//
// Ports
//   clk, rstn              read-domain clock, async active-low reset
//   enable                 permits starting / continuing frames
//   fifo_empty             FIFO empty flag
//   fifo_rd_data           show-ahead FIFO head (valid when !fifo_empty)
//   fifo_prefill           FIFO pre-fill reached (already synchronised)
//   fifo_rd_en             pop strobe (combinational)
//   m_valid/m_data/m_last  output stream (registered)
//   m_ready                downstream ready
//   busy                   state != IDLE (combinational)
//   frame_done             pulse when a last beat is accepted downstream
//   frame_cnt              completed frames, wraps
//   underrun_cnt           starved STREAM cycles, saturates
//
// state  | meaning
// IDLE   | waiting for enable && fifo_prefill
// STREAM | popping FIFO into the skid buffer, framing beats
// FLUSH  | frame finished with enable low; draining skid buffer

module fifo_stream_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAME_LEN  = 16,
  parameter int BEAT_W     = $clog2(FRAME_LEN + 1),
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_prefill,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  frame_done,
  output logic [CNT_W-1:0]      frame_cnt,
  output logic [CNT_W-1:0]      underrun_cnt
);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);

  state_t                state, state_nxt;
  logic [BEAT_W-1:0]     beat;
  logic [1:0]            occ, occ_nxt;
  logic [DATA_WIDTH-1:0] d1;
  logic                  l1;
  logic                  pop, accept, last_tag;

  assign pop      = fifo_rd_en;
  assign accept   = m_valid && m_ready;
  assign last_tag = (beat == LAST_BEAT);
  assign occ_nxt  = occ + {1'b0, pop} - {1'b0, accept};

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (enable && fifo_prefill) state_nxt = STREAM;
      // Only the last pop of a frame may leave STREAM, so frames are never cut.
      STREAM: if (pop && last_tag && !enable) state_nxt = FLUSH;
      FLUSH:  if (occ == 2'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Combinational outputs
  always_comb begin
    fifo_rd_en = (state == STREAM) && !fifo_empty && (occ != 2'd2);
    busy       = (state != IDLE);
  end

  // Beat counter; held at zero in IDLE so every STREAM entry starts a frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat <= '0;
    end else if (state == IDLE) begin
      beat <= '0;
    end else if (pop) begin
      beat <= last_tag ? '0 : beat + BEAT_W'(1);
    end
  end

  // Two-entry skid buffer. Entry 0 is the head and drives m_data/m_last
  // directly so they hold steady under back-pressure.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      occ     <= 2'd0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      d1      <= '0;
      l1      <= 1'b0;
    end else begin
      occ     <= occ_nxt;
      m_valid <= (occ_nxt != 2'd0);
      case ({pop, accept})
        2'b10: begin
          if (occ == 2'd0) begin
            m_data <= fifo_rd_data;
            m_last <= last_tag;
          end else begin
            d1 <= fifo_rd_data;
            l1 <= last_tag;
          end
        end
        2'b01: begin
          m_data <= d1;
          m_last <= l1;
        end
        // Push and accept together only happen with one entry held
        // (pop needs occ<2, accept needs occ>0), so the head is replaced.
        2'b11: begin
          m_data <= fifo_rd_data;
          m_last <= last_tag;
        end
        default: ;
      endcase
    end
  end

  // Frame completion and underrun statistics
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_done   <= 1'b0;
      frame_cnt    <= '0;
      underrun_cnt <= '0;
    end else begin
      frame_done <= accept && m_last;
      if (accept && m_last) frame_cnt <= frame_cnt + CNT_W'(1);
      if ((state == STREAM) && fifo_empty && (occ == 2'd0) && (underrun_cnt != '1))
        underrun_cnt <= underrun_cnt + CNT_W'(1);
    end
  end

endmodule
